// File: rtl/waitstate_ctrl.sv
// Programmable wait-state controller: stretches the E-high phase of the CLKX4
// E/Q clock generator per chip-select region, with an EXT_nWAIT watchdog.
module waitstate_ctrl #(
    parameter logic [15:0] WS_BASE        = 16'hFE40,
    parameter logic [2:0]  ROM_WS_RST     = 3'd1,
    parameter logic [2:0]  RAM_WS_RST     = 3'd0,
    parameter logic [2:0]  EXT_WS_RST     = 3'd3,
    parameter logic [2:0]  EXTIO_WS_RST   = 3'd3,
    parameter logic [2:0]  UART_WS_RST    = 3'd2,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        QX_i,
    input  logic        EX_i,
    input  logic [15:0] ADDR_i,
    input  logic        RnW_i,
    input  logic        HW_EN_i,
    input  logic [7:0]  DATA_i,
    output logic [7:0]  DATA_o,
    output logic        DATA_oe_o,
    input  logic        nCSROM0_i,
    input  logic        nCSROM1_i,
    input  logic        nCSRAM_i,
    input  logic        nCSEXT_i,
    input  logic        nCSEXTIO_i,
    input  logic        nCSUART_i,
    input  logic        EXT_nWAIT_i,
    output logic        MRDY_o,
    output logic        TIMEOUT_o,
    output logic [1:0]  state_o
);

    // Handshake: the clock generator samples MRDY on every CLKX4 edge while
    // {QX,EX}=01; MRDY=1 at that edge ends E-high, MRDY=0 repeats 01.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_STRETCH = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        mrdy_q, mrdy_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  sync_q;

    logic [2:0]  rom_ws_q, ram_ws_q, ext_ws_q, extio_ws_q, uart_ws_q;

    logic        reg_access;
    logic        wr_commit;
    logic        timeout_set;
    logic        timeout_clr;
    logic [2:0]  ws;
    logic        ext_sel;
    logic        wait_req;
    logic [2:0]  cnt_dec;
    logic [8:0]  tcnt_inc;

    assign reg_access = HW_EN_i && (ADDR_i[15:2] == WS_BASE[15:2]);
    assign DATA_oe_o  = EX_i && RnW_i && reg_access;

    // Commit only on the last E-high edge so a CPU cycle writes exactly once.
    assign wr_commit   = reg_access && !RnW_i && !QX_i && EX_i && mrdy_q;
    assign timeout_clr = wr_commit && (ADDR_i[1:0] == 2'd3) && DATA_i[7];

    always_comb begin
        ws      = 3'd0;
        ext_sel = 1'b0;
        if (!nCSEXTIO_i) begin
            ws      = extio_ws_q;
            ext_sel = 1'b1;
        end else if (!nCSEXT_i) begin
            ws      = ext_ws_q;
            ext_sel = 1'b1;
        end else if (!nCSUART_i) begin
            ws = uart_ws_q;
        end else if (!nCSROM0_i || !nCSROM1_i) begin
            ws = rom_ws_q;
        end else if (!nCSRAM_i) begin
            ws = ram_ws_q;
        end
    end

    assign wait_req = ext_sel && !sync_q[1];
    assign cnt_dec  = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
    assign tcnt_inc = {1'b0, tcnt_q} + 9'd1;

    always_comb begin
        state_d     = ST_IDLE;
        mrdy_d      = 1'b1;
        cnt_d       = 3'd0;
        tcnt_d      = 8'd0;
        timeout_set = 1'b0;
        case ({QX_i, EX_i})
            2'b11: begin
                state_d = ST_LOAD;
                cnt_d   = ws;
                mrdy_d  = (ws == 3'd0) && !wait_req;
            end
            2'b01: begin
                if (mrdy_q) begin
                    state_d = ST_DONE;
                    mrdy_d  = 1'b1;
                    cnt_d   = cnt_q;
                    tcnt_d  = tcnt_q;
                end else begin
                    state_d = ST_STRETCH;
                    cnt_d   = cnt_dec;
                    // Watchdog release overrides both the count and EXT_nWAIT.
                    if (tcnt_inc >= {1'b0, TIMEOUT_CYCLES}) begin
                        tcnt_d      = TIMEOUT_CYCLES;
                        mrdy_d      = 1'b1;
                        timeout_set = 1'b1;
                    end else begin
                        tcnt_d = tcnt_inc[7:0];
                        mrdy_d = (cnt_dec == 3'd0) && !wait_req;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                mrdy_d  = 1'b1;
                cnt_d   = 3'd0;
                tcnt_d  = 8'd0;
            end
        endcase
    end

    // A set on the same edge as a clear keeps the flag.
    always_comb begin
        timeout_d = timeout_q;
        if (timeout_clr) begin
            timeout_d = 1'b0;
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            mrdy_q    <= 1'b1;
            cnt_q     <= 3'd0;
            tcnt_q    <= 8'd0;
            timeout_q <= 1'b0;
            sync_q    <= 2'b11;
        end else begin
            state_q   <= state_d;
            mrdy_q    <= mrdy_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
            sync_q    <= {sync_q[0], EXT_nWAIT_i};
        end
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            rom_ws_q   <= ROM_WS_RST;
            ram_ws_q   <= RAM_WS_RST;
            ext_ws_q   <= EXT_WS_RST;
            extio_ws_q <= EXTIO_WS_RST;
            uart_ws_q  <= UART_WS_RST;
        end else if (wr_commit) begin
            case (ADDR_i[1:0])
                2'd0: begin
                    rom_ws_q <= DATA_i[2:0];
                    ram_ws_q <= DATA_i[6:4];
                end
                2'd1: begin
                    ext_ws_q   <= DATA_i[2:0];
                    extio_ws_q <= DATA_i[6:4];
                end
                2'd2: begin
                    uart_ws_q <= DATA_i[2:0];
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        DATA_o = 8'h00;
        if (reg_access && RnW_i) begin
            case (ADDR_i[1:0])
                2'd0:    DATA_o = {1'b0, ram_ws_q, 1'b0, rom_ws_q};
                2'd1:    DATA_o = {1'b0, extio_ws_q, 1'b0, ext_ws_q};
                2'd2:    DATA_o = {5'b0, uart_ws_q};
                default: DATA_o = {timeout_q, 7'b0};
            endcase
        end
    end

    assign MRDY_o    = mrdy_q;
    assign TIMEOUT_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_waitstate_ctrl.sv
// Bench for waitstate_ctrl: plays the E/Q clock generator and checks E-high
// length, register reads, DATA_oe and the TIMEOUT flag against a cycle-level model.
module tb_waitstate_ctrl;

    localparam logic [15:0] WS_BASE = 16'hFE40;
    localparam int          TO_CYC  = 255;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        QX, EX;
    logic [15:0] ADDR;
    logic        RnW, HW_EN;
    logic [7:0]  DATA_in;
    logic [7:0]  DATA_out;
    logic        DATA_oe;
    logic        nCSROM0, nCSROM1, nCSRAM, nCSEXT, nCSEXTIO, nCSUART;
    logic        EXT_nWAIT;
    logic        MRDY, TIMEOUT;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    waitstate_ctrl dut (
        .CLKX4      (clk),
        .nRESET     (nRESET),
        .QX_i       (QX),
        .EX_i       (EX),
        .ADDR_i     (ADDR),
        .RnW_i      (RnW),
        .HW_EN_i    (HW_EN),
        .DATA_i     (DATA_in),
        .DATA_o     (DATA_out),
        .DATA_oe_o  (DATA_oe),
        .nCSROM0_i  (nCSROM0),
        .nCSROM1_i  (nCSROM1),
        .nCSRAM_i   (nCSRAM),
        .nCSEXT_i   (nCSEXT),
        .nCSEXTIO_i (nCSEXTIO),
        .nCSUART_i  (nCSUART),
        .EXT_nWAIT_i(EXT_nWAIT),
        .MRDY_o     (MRDY),
        .TIMEOUT_o  (TIMEOUT),
        .state_o    (dbg_state)
    );

    // Reference model of the CPU-visible state.
    logic [2:0] m_rom = 3'd1, m_ram = 3'd0, m_ext = 3'd3, m_extio = 3'd3, m_uart = 3'd2;
    logic       m_to = 1'b0;
    logic [7:0] exp_q[$];

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rom = 3'd1; m_ram = 3'd0; m_ext = 3'd3; m_extio = 3'd3; m_uart = 3'd2;
        m_to  = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {1'b0, m_ram, 1'b0, m_rom};
            2'd1:    return {1'b0, m_extio, 1'b0, m_ext};
            2'd2:    return {5'b0, m_uart};
            default: return {m_to, 7'b0};
        endcase
    endfunction

    // cs bits (active high): [5]=EXTIO [4]=EXT [3]=UART [2]=ROM0 [1]=ROM1 [0]=RAM
    function automatic int model_ws(input logic [5:0] cs);
        if (cs[5]) return int'(m_extio);
        if (cs[4]) return int'(m_ext);
        if (cs[3]) return int'(m_uart);
        if (cs[2] || cs[1]) return int'(m_rom);
        if (cs[0]) return int'(m_ram);
        return 0;
    endfunction

    task automatic step(input int rel, inout int cyc);
        @(negedge clk);
        cyc++;
        if (cyc == rel) EXT_nWAIT = 1'b1;
    endtask

    // One CPU cycle. rel>0 holds EXT_nWAIT low from the 00 phase until rel
    // CLKX4 cycles later (a very large rel never releases within the cycle).
    task automatic cpu_cycle(input logic [15:0] addr, input logic rnw, input logic hw,
                             input logic [7:0] wdata, input logic [5:0] cs,
                             input int rel, input string tag);
        int   e_len, cyc, exp_e, wait_e;
        bit   ext, to_hit, reg_acc;
        logic [7:0] obs_rd, exp_rd;
        logic obs_oe;

        ext     = cs[5] || cs[4];
        reg_acc = hw && (addr[15:2] == WS_BASE[15:2]);
        exp_e   = 2 + model_ws(cs);
        to_hit  = 1'b0;
        if (ext && rel > 0) begin
            wait_e = rel + 2;
            if (wait_e > exp_e) exp_e = wait_e;
            if (rel >= TO_CYC) to_hit = 1'b1;
        end
        if (exp_e > TO_CYC + 2) exp_e = TO_CYC + 2;
        if (reg_acc && rnw) exp_q.push_back(model_read(addr[1:0]));

        @(negedge clk);
        cyc = 0;
        {QX, EX} = 2'b00;
        ADDR = addr; RnW = rnw; HW_EN = hw; DATA_in = wdata;
        nCSEXTIO = ~cs[5]; nCSEXT = ~cs[4]; nCSUART = ~cs[3];
        nCSROM0  = ~cs[2]; nCSROM1 = ~cs[1]; nCSRAM = ~cs[0];
        if (rel > 0) EXT_nWAIT = 1'b0;
        step(rel, cyc); {QX, EX} = 2'b10;
        step(rel, cyc); {QX, EX} = 2'b11;
        step(rel, cyc); {QX, EX} = 2'b01;
        e_len  = 2;
        obs_oe = DATA_oe;
        obs_rd = DATA_out;
        while (MRDY !== 1'b1 && e_len < 400) begin
            step(rel, cyc);
            e_len++;
        end
        step(rel, cyc);
        {QX, EX} = 2'b00;
        nCSEXTIO = 1'b1; nCSEXT = 1'b1; nCSUART = 1'b1;
        nCSROM0 = 1'b1; nCSROM1 = 1'b1; nCSRAM = 1'b1;
        HW_EN = 1'b0; RnW = 1'b1; EXT_nWAIT = 1'b1;

        if (to_hit) m_to = 1'b1;
        if (reg_acc && !rnw) begin
            case (addr[1:0])
                2'd0: begin m_rom = wdata[2:0]; m_ram = wdata[6:4]; end
                2'd1: begin m_ext = wdata[2:0]; m_extio = wdata[6:4]; end
                2'd2: m_uart = wdata[2:0];
                default: if (wdata[7]) m_to = 1'b0;
            endcase
        end

        check({tag, "_elen"}, e_len, exp_e);
        check({tag, "_oe"}, obs_oe, reg_acc && rnw);
        if (reg_acc && rnw) begin
            exp_rd = exp_q.pop_front();
            check({tag, "_rdata"}, obs_rd, exp_rd);
        end else begin
            check({tag, "_rdata_idle"}, obs_rd, 8'h00);
        end
        check({tag, "_timeout"}, TIMEOUT, m_to);
        check({tag, "_mrdy_after"}, MRDY, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] raddr;
        logic [5:0]  rcs;
        logic        rrnw, rhw;
        int          kind, rrel;

        nRESET = 1'b0; QX = 1'b0; EX = 1'b0; ADDR = 16'h0; RnW = 1'b1; HW_EN = 1'b0;
        DATA_in = 8'h00; EXT_nWAIT = 1'b1;
        nCSROM0 = 1'b1; nCSROM1 = 1'b1; nCSRAM = 1'b1;
        nCSEXT = 1'b1; nCSEXTIO = 1'b1; nCSUART = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_mrdy", MRDY, 1'b1);
        end
        check("reset_timeout", TIMEOUT, 1'b0);
        @(negedge clk);
        nRESET = 1'b1;

        for (int i = 0; i < 4; i++)
            cpu_cycle({WS_BASE[15:2], 2'(i)}, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_default");

        cpu_cycle(16'h1000, 1'b1, 1'b1, 8'h00, 6'b000001, 0, "ram");
        cpu_cycle(16'h1000, 1'b1, 1'b1, 8'h00, 6'b001000, 0, "uart");
        cpu_cycle(16'h1000, 1'b1, 1'b1, 8'h00, 6'b011000, 0, "ext_over_uart");
        cpu_cycle(16'h2000, 1'b1, 1'b1, 8'h00, 6'b010000, 10, "ext_wait");
        cpu_cycle(16'h2000, 1'b1, 1'b1, 8'h00, 6'b001000, 10, "uart_ignores_wait");

        cpu_cycle(WS_BASE, 1'b0, 1'b1, 8'h05, 6'b0, 0, "wr_rom5");
        cpu_cycle(16'hC000, 1'b1, 1'b1, 8'h00, 6'b000100, 0, "rom0");
        cpu_cycle(16'hC000, 1'b1, 1'b1, 8'h00, 6'b000010, 0, "rom1");
        cpu_cycle(WS_BASE, 1'b0, 1'b0, 8'h77, 6'b0, 0, "wr_noen");
        cpu_cycle(WS_BASE, 1'b1, 1'b0, 8'h00, 6'b0, 0, "rd_noen");
        cpu_cycle(WS_BASE, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_after_noen");

        cpu_cycle(WS_BASE + 16'd1, 1'b0, 1'b1, 8'h61, 6'b0, 0, "wr_ext61");
        cpu_cycle(WS_BASE + 16'd1, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_ext61");
        cpu_cycle(16'h3000, 1'b1, 1'b1, 8'h00, 6'b110000, 0, "extio_over_ext");
        cpu_cycle(16'h3000, 1'b1, 1'b1, 8'h00, 6'b011000, 0, "ext_over_uart2");
        cpu_cycle(16'h3000, 1'b1, 1'b1, 8'h00, 6'b001100, 0, "uart_over_rom");
        cpu_cycle(16'h3000, 1'b1, 1'b1, 8'h00, 6'b000011, 0, "rom_over_ram");
        cpu_cycle(WS_BASE + 16'd2, 1'b0, 1'b1, 8'hFF, 6'b000000, 0, "wr_uart_ff");
        cpu_cycle(WS_BASE + 16'd2, 1'b1, 1'b1, 8'h00, 6'b001000, 0, "rd_uart_ff");
        cpu_cycle(WS_BASE, 1'b0, 1'b1, 8'h00, 6'b000100, 0, "wr_during_rom");
        cpu_cycle(16'h3000, 1'b1, 1'b1, 8'h00, 6'b000100, 0, "rom_after_wr");

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 2);
            rrnw = 1'($urandom_range(0, 1));
            rhw  = ($urandom_range(0, 7) != 0);
            if (kind != 1) begin
                raddr = {WS_BASE[15:2], 2'($urandom_range(0, 3))};
            end else begin
                raddr = 16'($urandom);
                if (raddr[15:2] == WS_BASE[15:2]) raddr[15] = ~raddr[15];
            end
            rcs = 6'b0;
            if (kind != 0) begin
                for (int b = 0; b < 6; b++) rcs[b] = ($urandom_range(0, 2) == 0);
            end
            rrel = (rcs[5] || rcs[4]) ? $urandom_range(0, 20) : 0;
            cpu_cycle(raddr, rrnw, rhw, 8'($urandom), rcs, rrel, "rand");
        end

        cpu_cycle(16'h4000, 1'b1, 1'b1, 8'h00, 6'b100000, 100000, "timeout");
        cpu_cycle(WS_BASE + 16'd3, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_to_set");
        cpu_cycle(WS_BASE + 16'd3, 1'b0, 1'b1, 8'h7F, 6'b0, 0, "wr_to_noclr");
        cpu_cycle(WS_BASE + 16'd3, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_to_kept");
        cpu_cycle(WS_BASE + 16'd3, 1'b0, 1'b1, 8'h80, 6'b0, 0, "wr_to_clr");
        cpu_cycle(WS_BASE + 16'd3, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_to_clr");
        cpu_cycle(16'h4000, 1'b1, 1'b1, 8'h00, 6'b010000, 100000, "timeout2");

        // Reset while stretching a ROM cycle with five wait states loaded.
        cpu_cycle(WS_BASE, 1'b0, 1'b1, 8'h25, 6'b0, 0, "wr_rom5_again");
        @(negedge clk);
        {QX, EX} = 2'b00; ADDR = 16'hC000; nCSROM0 = 1'b0;
        @(negedge clk); {QX, EX} = 2'b10;
        @(negedge clk); {QX, EX} = 2'b11;
        @(negedge clk); {QX, EX} = 2'b01;
        @(negedge clk);
        check("stretch_before_reset", MRDY, 1'b0);
        nRESET = 1'b0;
        #1;
        check("mrdy_async_reset", MRDY, 1'b1);
        check("timeout_async_reset", TIMEOUT, 1'b0);
        model_reset();
        @(negedge clk);
        {QX, EX} = 2'b00; nCSROM0 = 1'b1;
        nRESET = 1'b1;
        for (int i = 0; i < 4; i++)
            cpu_cycle({WS_BASE[15:2], 2'(i)}, 1'b1, 1'b1, 8'h00, 6'b0, 0, "rd_after_reset");
        cpu_cycle(16'hC000, 1'b1, 1'b1, 8'h00, 6'b000100, 0, "rom_after_reset");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
